// File: rtl/data_cache_if.sv
// Bundle of CPU-side and memory-side signals of the data cache.
// The slave modport is the cache's view; the master modport drives it.
interface data_cache_if #(
  parameter int unsigned WORDS_PER_LINE = 4
);
  // CPU request
  logic                          is_input_valid;
  logic [31:0]                   addr;
  logic                          mem_read;
  logic                          mem_write;
  logic [31:0]                   din;
  // CPU response
  logic                          is_ready;
  logic                          is_output_valid;
  logic [31:0]                   dout;
  logic                          is_hit;
  // Memory request
  logic                          mem_req_valid;
  logic [31:0]                   mem_req_addr;
  logic                          mem_req_write;
  logic [32*WORDS_PER_LINE-1:0]  mem_req_wdata;
  logic                          mem_req_ready;
  // Memory response
  logic                          mem_resp_valid;
  logic [32*WORDS_PER_LINE-1:0]  mem_resp_rdata;

  modport slave (
    input  is_input_valid, addr, mem_read, mem_write, din,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output is_ready, is_output_valid, dout, is_hit,
    output mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata
  );

  modport master (
    output is_input_valid, addr, mem_read, mem_write, din,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  is_ready, is_output_valid, dout, is_hit,
    input  mem_req_valid, mem_req_addr, mem_req_write, mem_req_wdata
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one
// outstanding memory transaction (writeback and/or fill) at a time.
module data_cache #(
  parameter int unsigned NUM_SETS       = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic         clk,
  input  logic         reset,
  data_cache_if.slave  bus
);

  localparam int unsigned OFF_BITS = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_BITS = $clog2(NUM_SETS);
  localparam int unsigned TAG_BITS = 30 - OFF_BITS - IDX_BITS;

  typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL_REQ,
    FILL_WAIT
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [31:2]         addr_q;
  logic [31:0]         din_q;
  logic                wr_q;
  logic                missed_q;

  // Line storage
  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_BITS-1:0] tag_q  [NUM_SETS];
  line_t               data_q [NUM_SETS];

  logic [OFF_BITS-1:0] req_off;
  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0] req_tag;
  logic                lookup_hit;

  logic accept, miss, store_hit, wb_done, fill_done;

  assign req_off    = addr_q[OFF_BITS+1:2];
  assign req_idx    = addr_q[IDX_BITS+OFF_BITS+1:OFF_BITS+2];
  assign req_tag    = addr_q[31:32-TAG_BITS];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and all outputs; outputs are zero outside their owning
  // state, which also gives the required all-zero values after reset.
  always_comb begin
    state_d               = state_q;
    accept                = 1'b0;
    miss                  = 1'b0;
    store_hit             = 1'b0;
    wb_done               = 1'b0;
    fill_done             = 1'b0;
    bus.is_ready          = 1'b0;
    bus.is_output_valid   = 1'b0;
    bus.dout              = '0;
    bus.is_hit            = 1'b0;
    bus.mem_req_valid     = 1'b0;
    bus.mem_req_write     = 1'b0;
    bus.mem_req_addr      = '0;
    bus.mem_req_wdata     = '0;
    unique case (state_q)
      IDLE: begin
        bus.is_ready = 1'b1;
        if (bus.is_input_valid && (bus.mem_read || bus.mem_write)) begin
          accept  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (lookup_hit) begin
          bus.is_output_valid = 1'b1;
          bus.is_hit          = ~missed_q;
          if (wr_q) store_hit = 1'b1;
          else      bus.dout  = data_q[req_idx][req_off];
          state_d = IDLE;
        end else begin
          miss = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) state_d = WRITEBACK;
          else                                       state_d = FILL_REQ;
        end
      end
      WRITEBACK: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = {tag_q[req_idx], req_idx, {(OFF_BITS+2){1'b0}}};
        bus.mem_req_wdata = data_q[req_idx];
        if (bus.mem_req_ready) begin
          wb_done = 1'b1;
          state_d = FILL_REQ;
        end
      end
      FILL_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {req_tag, req_idx, {(OFF_BITS+2){1'b0}}};
        if (bus.mem_req_ready) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (bus.mem_resp_valid) begin
          fill_done = 1'b1;
          state_d   = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture; missed_q remembers that the first lookup failed
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      din_q    <= '0;
      wr_q     <= 1'b0;
      missed_q <= 1'b0;
    end else if (accept) begin
      addr_q   <= bus.addr[31:2];
      din_q    <= bus.din;
      wr_q     <= bus.mem_write;
      missed_q <= 1'b0;
    end else if (miss) begin
      missed_q <= 1'b1;
    end
  end

  // Valid/dirty bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_done) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
      if (wb_done)   dirty_q[req_idx] <= 1'b0;
      if (store_hit) dirty_q[req_idx] <= 1'b1;
    end
  end

  // Tag and data arrays, not reset
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= bus.mem_resp_rdata;
    end else if (store_hit) begin
      data_q[req_idx][req_off] <= din_q;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a response scoreboard, a memory-request
// scoreboard and a simple memory responder.
module tb_data_cache;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_cache_if #(.WORDS_PER_LINE(4)) bus ();

  data_cache #(.NUM_SETS(16), .WORDS_PER_LINE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dout;
    logic        hit;
    int unsigned cyc;
    int unsigned lat;
  } resp_t;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mreq_t;

  resp_t exp_q[$];
  mreq_t mexp_q[$];

  logic [127:0] mem_a [logic [31:0]];
  int unsigned  stall      = 0;
  int unsigned  fill_delay = 2;
  int unsigned  late_delay = 6;
  logic         late_fill  = 1'b0;

  logic         resp_v_mem  = 1'b0;
  logic         resp_v_stim = 1'b0;
  logic [127:0] rdata_mem   = '0;
  logic [127:0] rdata_stim  = '0;
  assign bus.mem_resp_valid = resp_v_mem | resp_v_stim;
  assign bus.mem_resp_rdata = resp_v_stim ? rdata_stim : rdata_mem;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lines not preloaded hold their own word addresses
  function automatic logic [127:0] line_of(input logic [31:0] a);
    if (mem_a.exists(a)) return mem_a[a];
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  // Monitor: pops the scoreboards whenever the DUT presents something
  initial begin
    resp_t e;
    mreq_t m;
    forever begin
      @(negedge clk);
      if (!reset && bus.is_output_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_response: dout %0h is_hit %0b, none expected", bus.dout, bus.is_hit);
        end else begin
          e = exp_q.pop_front();
          check("dout", bus.dout, e.dout);
          check("is_hit", bus.is_hit, e.hit);
          if (e.lat != 0) check("hit_latency", cyc - e.cyc, e.lat);
        end
      end else if (!reset) begin
        check("dout_idle_zero", bus.dout, 32'h0);
      end
      if (!reset && bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1) begin
        if (mexp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_mem_req: addr %0h write %0b, none expected", bus.mem_req_addr, bus.mem_req_write);
        end else begin
          m = mexp_q.pop_front();
          check("mem_req_write", bus.mem_req_write, m.wr);
          check("mem_req_addr", bus.mem_req_addr, m.addr);
          if (m.wr) check("mem_req_wdata", bus.mem_req_wdata, m.wdata);
        end
      end
    end
  end

  // Memory responder: optional stall, one-cycle ready, delayed fill data
  initial begin
    logic [31:0]  ca;
    logic         cw;
    logic [127:0] cd;
    bus.mem_req_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.mem_req_valid === 1'b1) begin
        ca = bus.mem_req_addr;
        cw = bus.mem_req_write;
        cd = bus.mem_req_wdata;
        for (int i = 0; i < int'(stall); i++) begin
          check("bp_req_valid", bus.mem_req_valid, 1'b1);
          check("bp_req_addr", bus.mem_req_addr, ca);
          check("bp_is_ready", bus.is_ready, 1'b0);
          @(negedge clk);
        end
        @(posedge clk); #1 bus.mem_req_ready = 1'b1;
        @(posedge clk); #1 bus.mem_req_ready = 1'b0;
        if (cw) begin
          mem_a[ca] = cd;
        end else begin
          if (late_fill) repeat (late_delay) @(posedge clk);
          else           repeat (fill_delay) @(posedge clk);
          #1;
          resp_v_mem = 1'b1;
          rdata_mem  = line_of(ca);
          @(posedge clk); #1 resp_v_mem = 1'b0;
        end
      end
    end
  end

  task automatic exp_mem(input logic wr, input logic [31:0] a, input logic [127:0] wd);
    mreq_t m;
    m.wr = wr; m.addr = a; m.wdata = wd;
    mexp_q.push_back(m);
  endtask

  task automatic cpu_issue(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic want,
                           input logic [31:0] edout, input logic ehit,
                           input int unsigned lat);
    resp_t e;
    int unsigned t;
    t = 0;
    @(negedge clk);
    while (bus.is_ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout: is_ready %0b, required 1", bus.is_ready);
    end
    @(posedge clk); #1;
    bus.is_input_valid = 1'b1;
    bus.mem_read       = rd;
    bus.mem_write      = wr;
    bus.addr           = a;
    bus.din            = d;
    if (want) begin
      e.dout = edout; e.hit = ehit; e.cyc = cyc; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.is_input_valid = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
  endtask

  task automatic cpu_wait();
    int unsigned t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL response_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] edout, input logic ehit, input int unsigned lat);
    cpu_issue(rd, wr, a, d, 1'b1, edout, ehit, lat);
    cpu_wait();
  endtask

  task automatic wait_fill_hs();
    int unsigned t;
    t = 0;
    @(negedge clk);
    while (!(bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b1 &&
             bus.mem_req_write === 1'b0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL fill_handshake_timeout: mem_req_valid %0b, required 1", bus.mem_req_valid);
    end
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    bus.is_input_valid = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.addr           = '0;
    bus.din            = '0;
    mem_a[32'h100] = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_is_ready", bus.is_ready, 1'b1);
    check("rst_out_valid", bus.is_output_valid, 1'b0);
    check("rst_is_hit", bus.is_hit, 1'b0);
    check("rst_dout", bus.dout, 32'h0);
    check("rst_req_valid", bus.mem_req_valid, 1'b0);
    check("rst_req_write", bus.mem_req_write, 1'b0);
    check("rst_req_addr", bus.mem_req_addr, 32'h0);
    check("rst_req_wdata", bus.mem_req_wdata, 128'h0);

    // Cold load, then hits
    exp_mem(1'b0, 32'h100, '0);
    txn(1'b1, 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    txn(1'b1, 1'b0, 32'h104, 32'h0, 32'hDEAD_BEEF, 1'b1, 1);
    txn(1'b1, 1'b0, 32'h10C, 32'h0, 32'h3333_3333, 1'b1, 1);

    // Store hit, read back, then evict the dirty line
    txn(1'b0, 1'b1, 32'h104, 32'h1234_5678, 32'h0, 1'b1, 1);
    txn(1'b1, 1'b0, 32'h104, 32'h0, 32'h1234_5678, 1'b1, 1);
    exp_mem(1'b1, 32'h100, {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h1111_1111});
    exp_mem(1'b0, 32'h1100, '0);
    txn(1'b1, 1'b0, 32'h1104, 32'h0, 32'h0000_1104, 1'b0, 0);

    // Backpressure on the fill request
    stall = 5;
    exp_mem(1'b0, 32'h200, '0);
    txn(1'b1, 1'b0, 32'h208, 32'h0, 32'h0000_0208, 1'b0, 0);
    stall = 0;

    // Store miss merges into the filled line
    exp_mem(1'b0, 32'h310, '0);
    txn(1'b0, 1'b1, 32'h314, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
    txn(1'b1, 1'b0, 32'h314, 32'h0, 32'hA5A5_A5A5, 1'b1, 1);
    txn(1'b1, 1'b0, 32'h318, 32'h0, 32'h0000_0318, 1'b1, 1);

    // Read and write both set acts as a store
    txn(1'b1, 1'b1, 32'h318, 32'h0000_0055, 32'h0, 1'b1, 1);
    txn(1'b1, 1'b0, 32'h318, 32'h0, 32'h0000_0055, 1'b1, 1);

    // Requests during FILL_WAIT are ignored
    fill_delay = 8;
    exp_mem(1'b0, 32'h420, '0);
    cpu_issue(1'b1, 1'b0, 32'h428, 32'h0, 1'b1, 32'h0000_0428, 1'b0, 0);
    wait_fill_hs();
    @(posedge clk); #1;
    bus.is_input_valid = 1'b1; bus.mem_read = 1'b1; bus.addr = 32'h314;
    @(posedge clk); #1;
    bus.mem_write = 1'b1; bus.addr = 32'h104;
    @(posedge clk); #1;
    bus.is_input_valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(negedge clk);
    check("fill_wait_not_ready", bus.is_ready, 1'b0);
    cpu_wait();
    fill_delay = 2;

    // Stray fill data in IDLE
    @(posedge clk); #1;
    resp_v_stim = 1'b1; rdata_stim = '1;
    @(posedge clk); #1;
    resp_v_stim = 1'b0;
    @(negedge clk);
    check("stray_resp_idle", bus.is_ready, 1'b1);

    // Strobe with no operation selected
    @(posedge clk); #1;
    bus.is_input_valid = 1'b1; bus.addr = 32'h314;
    @(posedge clk); #1;
    bus.is_input_valid = 1'b0;
    @(negedge clk);
    check("no_op_ignored", bus.is_ready, 1'b1);
    txn(1'b1, 1'b0, 32'h428, 32'h0, 32'h0000_0428, 1'b1, 1);

    // Reset while waiting for fill data; late data must be dropped
    late_fill  = 1'b1;
    late_delay = 6;
    exp_mem(1'b0, 32'h100, '0);
    cpu_issue(1'b1, 1'b0, 32'h104, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    wait_fill_hs();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", bus.is_ready, 1'b1);
    repeat (8) @(negedge clk);
    check("late_resp_ignored", bus.is_ready, 1'b1);
    late_fill = 1'b0;
    exp_mem(1'b0, 32'h100, '0);
    txn(1'b1, 1'b0, 32'h104, 32'h0, 32'h1234_5678, 1'b0, 0);

    repeat (5) @(negedge clk);
    check("resp_queue_empty", exp_q.size(), 0);
    check("mem_queue_empty", mexp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The parameter list SHALL be: NUM_SETS, default 16, number of direct-mapped lines; WORDS_PER_LINE, default 4, 32-bit words per line (line = 128 bits).
REQ-002 The ports SHALL be: clk input 1 clock; reset input 1 reset, synchronous, active-high.
REQ-003 The CPU-side request ports SHALL be: is_input_valid in 1 request strobe; addr in 32 byte address; mem_read in 1 load; mem_write in 1 store; din in 32 store data.
REQ-004 The CPU-side response ports SHALL be: is_ready out 1 can accept a request; is_output_valid out 1 response pulse; dout out 32 load data; is_hit out 1 original lookup hit.
REQ-005 The memory-side request ports SHALL be: mem_req_valid out 1; mem_req_addr out 32 line-aligned; mem_req_write out 1 (1 = writeback, 0 = fill); mem_req_wdata out 128; mem_req_ready in 1.
REQ-006 The memory-side response ports SHALL be: mem_resp_valid in 1 fill data strobe; mem_resp_rdata in 128 fill line, word 0 in bits [31:0].

Function
REQ-007 The address SHALL decode as: bits [1:0] ignored; bits [3:2] word offset; bits [7:4] index; bits [31:8] tag (24 bits) at default parameters.
REQ-008 Each line SHALL hold valid, dirty, tag and 128-bit data; the policy SHALL be write-back, write-allocate.
REQ-009 The FSM states SHALL be IDLE, COMPARE, WRITEBACK, FILL_REQ, FILL_WAIT.
REQ-010 IDLE SHALL assert is_ready=1; in all other states is_ready SHALL be 0.
REQ-011 A request SHALL be accepted in IDLE when is_input_valid=1 and (mem_read or mem_write) is 1. Acceptance latches addr, din and op, then moves to COMPARE.
REQ-012 A request that is not in IDLE, or that has neither mem_read nor mem_write set, SHALL be ignored.
REQ-013 When mem_read and mem_write are both 1, the request SHALL be treated as a store.
REQ-014 On a COMPARE hit (valid and tag equal), a load SHALL pulse is_output_valid for one cycle with dout = addressed word; a store SHALL write din into the word and set dirty, and SHALL also pulse is_output_valid. The FSM then returns to IDLE.
REQ-015 Hit latency SHALL be exactly 1 cycle: the response appears in the cycle after acceptance.
REQ-016 On a miss with a valid, dirty victim, COMPARE SHALL move to WRITEBACK. On a miss otherwise, COMPARE SHALL move to FILL_REQ.
REQ-017 WRITEBACK SHALL hold mem_req_valid=1 and mem_req_write=1, with mem_req_addr = {victim tag, index, 4'b0} and mem_req_wdata = the victim line. When mem_req_ready=1 the FSM SHALL move to FILL_REQ and clear dirty.
REQ-018 FILL_REQ SHALL hold mem_req_valid=1 and mem_req_write=0, with mem_req_addr = {request tag, index, 4'b0}. When mem_req_ready=1 the FSM SHALL move to FILL_WAIT.
REQ-019 In FILL_WAIT, when mem_resp_valid=1, the line SHALL load mem_resp_rdata with valid=1, dirty=0 and tag set. The FSM SHALL then return to COMPARE to replay the request, which now hits.
REQ-020 is_hit SHALL reflect the first lookup of the request: 1 for a hit, 0 for any request that needed a fill. It SHALL be valid only while is_output_valid=1.
REQ-021 mem_req_valid, once asserted, SHALL stay asserted with stable addr/write/wdata until mem_req_ready=1.
REQ-022 mem_resp_valid outside FILL_WAIT SHALL be ignored.
REQ-023 dout SHALL be 0 whenever is_output_valid=0 or the completed op was a store.
REQ-024 A store miss SHALL merge din into the filled line during the replay COMPARE, leaving the line dirty.
REQ-025 The cache SHALL have at most one outstanding memory request at a time.
REQ-026 Data arrays SHALL be registers, with no initial-file load.

Reset
REQ-027 When reset=1 at a clk edge, the block SHALL: set state to IDLE; clear all valid and dirty bits; set is_output_valid=0, is_hit=0, dout=0, mem_req_valid=0, mem_req_write=0; and drive mem_req_addr and mem_req_wdata to 0.
REQ-028 Reset mid-operation SHALL abandon the in-flight request with no response. A mem_resp_valid arriving after reset SHALL be ignored.
REQ-029 Tag and data contents SHALL be don't-care after reset, but SHALL never produce a hit while valid=0.

Verification
REQ-030 Cold load: after reset, load addr 0x0000_0104 -> FILL_REQ with mem_req_addr=0x0000_0100 and write=0. Memory returns word1=0xDEADBEEF -> one is_output_valid pulse with dout=0xDEADBEEF and is_hit=0.
REQ-031 Hit: repeat the load of 0x104 -> is_output_valid in the next cycle, dout=0xDEADBEEF, is_hit=1, and no memory request.
REQ-032 Store hit then eviction: store 0x12345678 to 0x104 (hit, dirty), then load 0x0000_1104 (same index, new tag) -> WRITEBACK to 0x100 with wdata[63:32]=0x12345678, then a fill at 0x1100.
REQ-033 Backpressure: hold mem_req_ready=0 for 5 cycles in FILL_REQ -> mem_req_valid and mem_req_addr stay stable and is_ready=0 throughout, then proceed on ready.
REQ-034 Ignored inputs: is_input_valid pulses during FILL_WAIT, plus a stray mem_resp_valid in IDLE -> no state change and no extra responses.
REQ-035 Reset in FILL_WAIT: a late mem_resp_valid is ignored; reloading 0x104 misses again (is_hit=0).
